// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit with stall, branch flush and halt
module inst_fetch #(
    parameter int A = 16,
    parameter int W = 9
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [A-1:0] i_start_addr,
    input  logic         i_stall,
    input  logic         i_branch_en,
    input  logic         i_branch_rel,
    input  logic [A-1:0] i_target,
    input  logic         i_halt,
    input  logic [W-1:0] i_inst_in,
    output logic [A-1:0] o_prog_ctr,
    output logic [W-1:0] o_inst_out,
    output logic [A-1:0] o_inst_addr,
    output logic         o_inst_valid,
    output logic         o_done,
    output logic [15:0]  o_fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t       r_state;
    logic [A-1:0] r_pc;
    logic [W-1:0] r_inst;
    logic [A-1:0] r_inst_addr;
    logic         r_valid;
    logic         r_done;
    logic [15:0]  r_count;

    state_t       w_state_nxt;
    logic [A-1:0] w_pc_nxt;
    logic [W-1:0] w_inst_nxt;
    logic [A-1:0] w_inst_addr_nxt;
    logic         w_valid_nxt;
    logic         w_done_nxt;
    logic [15:0]  w_count_nxt;
    logic [A-1:0] w_branch_pc;

    // Relative targets are two's-complement offsets; the A-bit sum wraps naturally.
    assign w_branch_pc = i_branch_rel ? (r_inst_addr + i_target) : i_target;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_inst      <= '0;
            r_inst_addr <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_inst      <= w_inst_nxt;
            r_inst_addr <= w_inst_addr_nxt;
            r_valid     <= w_valid_nxt;
            r_done      <= w_done_nxt;
            r_count     <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_inst_nxt      = r_inst;
        w_inst_addr_nxt = r_inst_addr;
        w_valid_nxt     = r_valid;
        w_done_nxt      = r_done;
        w_count_nxt     = r_count;

        case (r_state)
            S_IDLE, S_HALTED: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = i_start_addr;
                    w_valid_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    w_count_nxt = '0;
                end
            end
            S_RUN: begin
                // Halt and branch only apply to a valid instruction; stall always applies.
                if (r_valid && i_halt) begin
                    w_state_nxt = S_HALTED;
                    w_done_nxt  = 1'b1;
                    w_valid_nxt = 1'b0;
                end else if (i_stall) begin
                    w_state_nxt = S_RUN;
                end else if (r_valid && i_branch_en) begin
                    w_pc_nxt    = w_branch_pc;
                    w_valid_nxt = 1'b0;
                end else begin
                    w_inst_nxt      = i_inst_in;
                    w_inst_addr_nxt = r_pc;
                    w_valid_nxt     = 1'b1;
                    w_pc_nxt        = r_pc + {{(A-1){1'b0}}, 1'b1};
                    if (r_count != 16'hFFFF) begin
                        w_count_nxt = r_count + 16'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_prog_ctr    = r_pc;
    assign o_inst_out    = r_inst;
    assign o_inst_addr   = r_inst_addr;
    assign o_inst_valid  = r_valid;
    assign o_done        = r_done;
    assign o_fetch_count = r_count;

endmodule
